// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Holds the TX state encoding, line levels and the baud divisor calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Integer division: any fractional remainder of the ratio is dropped.
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO: rdata presents the oldest entry whenever !empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (cnt == (AW+1)'(FIFO_DEPTH));
  assign empty = (cnt == '0);
  assign wr_ok = push && (!full || pop);
  assign rd_ok = pop && !empty;
  assign rdata = mem[rd_ptr];
  assign count = cnt;

  // NOTE: storage is deliberately not reset; validity comes from the pointers and count, so a flush only clears those.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter with back-to-back framing and a registered tx pin.
// Define UART_TX_PARITY_EN to add the parity bit and the parity_odd select input.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int WIDTH      = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef UART_TX_PARITY_EN
  input  logic                        parity_odd,
`endif
  input  logic [WIDTH-1:0]            data,
  input  logic                        data_en,
  output logic                        tx,
  output logic                        tx_busy,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W    = $clog2(WIDTH);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  tx_state_t         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              ovf_q;
  logic              pop;
  logic              baud_last;
  logic [WIDTH-1:0]  fifo_rdata;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  uart_sync_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_en),
    .wdata (data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign baud_last = (baud_q == BAUD_LAST);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_last ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (baud_last) state_d = DATA;
      end
      DATA: begin
        if (baud_last) begin
          if (bit_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            bit_d = '0;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_last) state_d = STOP;
      end
`endif
      STOP: begin
        if (baud_last) begin
          if (bit_q == STOP_LAST) begin
            // Chain straight into the next start bit when more data is queued.
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      shift_d = fifo_rdata;
      bit_d   = '0;
      baud_d  = '0;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo_rdata ^ parity_odd;
`endif
    end

    // tx is derived from the next state so the pin register changes on the same edge as the FSM.
    case (state_d)
      START:   tx_d = START_LEVEL;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= IDLE_LEVEL;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      ovf_q   <= data_en && fifo_full && !pop;
    end
  end

  // Data path only; it is reloaded on every pop before being shifted out.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign tx       = tx_q;
  assign tx_busy  = (state_q != IDLE);
  assign overflow = ovf_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the single-byte TX. Adds:
- A configurable-depth transmit FIFO, so software can queue several characters.
- Configurable data width and stop-bit count.
- Back-to-back framing with no idle gap between queued characters.
- Optional parity, selected by a macro.
Sits between the register/bus interface and the serial TX pin; the line is idle-high.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate. BAUD_DIV = CLK_FREQ/BAUD_RATE, integer division, so 434 at the defaults.
- WIDTH, 8: data bits per frame. Legal range 5..9.
- STOP_BITS, 1: number of stop bits. Legal values 1 or 2.
- FIFO_DEPTH, 4: TX FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low: asserted when 0 and sampled on the rising clk edge.
- data  in  WIDTH  character to queue.
- data_en  in  1  write strobe; one cycle per character.
- tx  out  1  serial output, idle high.
- tx_busy  out  1  high while a frame is on the line (FSM not IDLE).
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- fifo_empty  out  1  FIFO holds 0 entries.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  one-cycle pulse when a write is dropped.
- parity_odd  in  1  only when UART_TX_PARITY_EN is defined: 0 selects even parity, 1 selects odd.

Behaviour:
- Reset (rst==0 at an edge):
  - Outputs: tx=1, tx_busy=0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0.
  - FSM goes to IDLE; baud and bit counters are cleared.
  - Reset mid-frame aborts the frame: tx is high after that edge and the FIFO is flushed.
- FIFO write:
  - A write is accepted when data_en==1 && (!fifo_full || pop in the same cycle).
  - If data_en==1 and the FIFO is full with no pop that cycle, the data is dropped and overflow pulses high for 1 cycle.
  - Count update: count = count + wr - rd. A simultaneous push and pop leaves the count unchanged.
  - The FIFO is first-in first-out, and the read/write pointers wrap modulo FIFO_DEPTH.
- Pop: occurs in IDLE when !fifo_empty, or at the end of the last stop bit when !fifo_empty. The popped word is latched into the shift register.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. On pop, go to START.
  - START: tx=0 for BAUD_DIV clocks, then go to DATA.
  - DATA: send WIDTH bits LSB first, BAUD_DIV clocks each. bit_c counts 0..WIDTH-1. Then go to PARITY (when enabled) or STOP.
  - PARITY: tx = ^data for even parity, ~^data for odd, for BAUD_DIV clocks. Then go to STOP.
  - STOP: tx=1 for STOP_BITS*BAUD_DIV clocks. Then go to START if the FIFO is non-empty (pop that cycle), otherwise to IDLE.
- Baud counter: counts 0..BAUD_DIV-1 and wraps. The bit advances on the cycle where the counter equals BAUD_DIV-1. The counter is cleared on entry to START from IDLE.
- Latency:
  - data_en sampled at edge N with the FIFO empty and FSM in IDLE: entry written at N, popped at N+1, tx falls after edge N+1.
  - Back-to-back frames: the first START bit begins the clock after the last stop-bit clock, with no idle cycles.
- tx is registered and glitch-free. tx_busy falls on the same edge that the FSM enters IDLE.

Optional Feature:
UART_TX_PARITY_EN
- Defined: the PARITY state and the parity_odd port exist, and the frame is 1 + WIDTH + 1 + STOP_BITS bits.
- Undefined: no parity_odd port, the PARITY state is removed, DATA goes directly to STOP, and the frame is 1 + WIDTH + STOP_BITS bits.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - the function baud_div(clk_freq, baud_rate);
  - shared constants (IDLE_LEVEL=1'b1, START_LEVEL=1'b0).
- Sub-module uart_sync_fifo (params WIDTH, FIFO_DEPTH) provides push, pop, rdata, full, empty and count. Show-ahead read: rdata is valid whenever !empty.
- The top level holds the FSM, baud counter, shift register and parity logic.

Test Plan:
- Reset, then write 8'd66 (0x42), defaults, no parity. Expected tx sequence, each bit 434 clocks: 0 | 0,1,0,0,0,0,1,0 | 1. tx_busy is high for 4340 clocks, then low; tx stays 1 while idle.
- Write 8'd66, 8'd111 and 8'hA7 on three consecutive cycles. Three frames follow back-to-back with no idle gap (total 13020 busy clocks), and fifo_count peaks at 2.
- Write 6 bytes on consecutive cycles with FIFO_DEPTH=4. The first byte is popped, 4 are queued, and the 6th write pulses overflow and is dropped; only 5 frames appear on tx.
- UART_TX_PARITY_EN defined, write 8'hA7 (five ones). With parity_odd=0 the parity bit is 1; with parity_odd=1 it is 0. The frame is 11 bits (4774 clocks).
- STOP_BITS=2 with WIDTH=7, write 7'h55: tx shows 0, then 1,0,1,0,1,0,1, then 1 held for 868 clocks.
- Pull rst low in the middle of the DATA bits of the 2nd of 3 queued frames. After that edge, tx=1, tx_busy=0 and fifo_empty=1, and no further frames are sent.
